// File: rtl/xps2_tx_pkg.sv
// xps2_tx_pkg: shared state encoding, status bit indices and frame bit numbers for the PS/2 host transmitter
package xps2_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, DONE, ERROR} state_t;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR = 2;
  localparam logic [3:0] BIT_PAR = 4'd9;
  localparam logic [3:0] BIT_STOP = 4'd10;
  localparam logic [3:0] BIT_ACK = 4'd11;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/xps2_tx_sync.sv
// xps2_tx_sync: ps2_clk/ps2_data synchroniser with a falling-edge pulse for ps2_clk
module xps2_tx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_fall,
  output logic clk_lvl,
  output logic data_lvl
);
  logic [SYNC_STAGES:0] c;
  logic [SYNC_STAGES-1:0] d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c <= '1;
      d <= '1;
    end else begin
      c <= {c[SYNC_STAGES-1:0], ps2_clk_in};
      d <= {d[SYNC_STAGES-2:0], ps2_data_in};
    end
  assign clk_lvl = c[SYNC_STAGES-1];
  assign clk_fall = c[SYNC_STAGES] & ~c[SYNC_STAGES-1];
  assign data_lvl = d[SYNC_STAGES-1];
endmodule

// File: rtl/xps2_tx.sv
// xps2_tx: PS/2 host-to-device command transmitter; define XPS2_TX_WDOG_EN for the device-edge watchdog
module xps2_tx
  import xps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [2:0] data_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] n, n_n, e;
  logic [7:0] byte_r, byte_n;
  logic par, par_n, bit_oe, bit_oe_n, done, done_n, err, err_n;
  logic fall, clk_lvl, data_lvl, busy;

  xps2_tx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_fall(fall),
    .clk_lvl(clk_lvl),
    .data_lvl(data_lvl)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      byte_r <= '0;
      par <= 1'b0;
      bit_oe <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      n <= n_n;
      byte_r <= byte_n;
      par <= par_n;
      bit_oe <= bit_oe_n;
      done <= done_n;
      err <= err_n;
    end

  // e is the number of the device falling edge being handled (1..11)
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    n_n = n;
    byte_n = byte_r;
    par_n = par;
    bit_oe_n = bit_oe;
    done_n = done;
    err_n = err;
    e = n + 4'd1;
    case (state)
      IDLE: if (sel && we) begin
        state_n = INHIBIT;
        cnt_n = CW'(INHIBIT_CYCLES - 1);
        byte_n = data_in;
        par_n = odd_parity(data_in);
        done_n = 1'b0;
        err_n = 1'b0;
      end
      INHIBIT: begin
        cnt_n = cnt - CW'(1);
        state_n = cnt == '0 ? REQ : INHIBIT;
      end
      REQ: begin
        state_n = BITS;
        n_n = '0;
        bit_oe_n = 1'b1;
        cnt_n = CW'(TIMEOUT_CYCLES - 1);
      end
      BITS: if (fall) begin
        n_n = e;
        bit_oe_n = e == BIT_STOP ? 1'b0 : e == BIT_PAR ? ~par : ~byte_r[n[2:0]];
        state_n = e == BIT_ACK ? (data_lvl ? ERROR : ACK) : BITS;
      end
      ACK: state_n = clk_lvl && data_lvl ? DONE : ACK;
      DONE: begin
        done_n = 1'b1;
        state_n = IDLE;
      end
      ERROR: begin
        err_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef XPS2_TX_WDOG_EN
    if (state == BITS || state == ACK) begin
      cnt_n = fall ? CW'(TIMEOUT_CYCLES - 1) : cnt - CW'(1);
      if (!fall && cnt == '0) state_n = ERROR;
    end
`endif
  end

  assign busy = state inside {INHIBIT, REQ, BITS, ACK};
  assign rx_inhibit = busy;
  assign ps2_clk_oe = state inside {INHIBIT, REQ};
  assign ps2_data_oe = state == REQ || (state == INHIBIT && cnt == '0) || (state == BITS && bit_oe);

  always_comb begin
    data_out = '0;
    data_out[ST_BUSY] = busy;
    data_out[ST_DONE] = done;
    data_out[ST_ERR] = err;
  end
endmodule

// File: tb/tb_xps2_tx.sv
// tb_xps2_tx: drives xps2_tx with a modelled PS/2 device and checks frames against a byte-level reference
module tb_xps2_tx;
  localparam int INH = 50;
  localparam int TMO = 1000;
  localparam int H = 20;
  logic clk = 0, rst = 1, sel = 0, we = 0;
  logic [7:0] data_in = 0;
  logic [2:0] data_out;
  logic ps2_clk_oe, ps2_data_oe, rx_inhibit;
  logic dev_clk = 1, dev_data = 1;
  logic ps2_clk, ps2_data;
  int errors = 0, checks = 0;

  assign ps2_clk = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  xps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .we(we),
    .data_in(data_in),
    .data_out(data_out),
    .ps2_clk_in(ps2_clk),
    .ps2_data_in(ps2_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .rx_inhibit(rx_inhibit)
  );

  // Line levels the device should see: start 0, d0..d7, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    sel = 1;
    we = 1;
    data_in = b;
    @(negedge clk);
    sel = 0;
    we = 0;
  endtask

  // Device: waits for the host request, then clocks `edges` falling edges, sampling on rising edges
  task automatic device_frame(input int edges, input bit ack, output logic [10:0] smp, output int low_len, output bit inh_ok);
    int w;
    w = 0;
    smp = '1;
    low_len = 0;
    inh_ok = 1;
    while (!ps2_clk_oe && w < 100) begin
      w++;
      @(negedge clk);
    end
    while (ps2_clk_oe && low_len < 4 * INH) begin
      low_len++;
      if (!rx_inhibit) inh_ok = 0;
      @(negedge clk);
    end
    if (ps2_clk_oe) low_len = -1;
    smp[0] = ps2_data;
    for (int k = 1; k <= edges; k++) begin
      if (k == 11 && ack) dev_data = 0;
      repeat (H) @(negedge clk);
      if (!rx_inhibit) inh_ok = 0;
      dev_clk = 0;
      repeat (H) @(negedge clk);
      dev_clk = 1;
      if (k <= 10) begin
        smp[k] = ps2_data;
        if (!rx_inhibit) inh_ok = 0;
      end
    end
    repeat (H) @(negedge clk);
    dev_data = 1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (data_out !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", data_out); end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++;
    if (rx_inhibit !== 1'b0) begin errors++; $display("FAIL reset_inhibit: got %b want 0", rx_inhibit); end
  endtask

  task automatic test_ed;
    logic [10:0] smp;
    int low;
    bit inh;
    write_byte(8'hED);
    checks++;
    if (data_out !== 3'b001 || ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL ed_busy_next: got status=%b clk_oe=%b want 001 1", data_out, ps2_clk_oe); end
    device_frame(11, 1, smp, low, inh);
    checks++;
    if (low < INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d want >=%0d", low, INH); end
    checks++;
    if (smp !== frame_of(8'hED)) begin errors++; $display("FAIL ed_frame: got %b want %b", smp, frame_of(8'hED)); end
    repeat (10) @(negedge clk);
    checks++;
    if (data_out !== 3'b010) begin errors++; $display("FAIL ed_status: got %b want 010", data_out); end
  endtask

  task automatic test_random;
    logic [10:0] smp;
    logic [7:0] b;
    int low;
    bit inh;
    for (int i = 0; i < 5; i++) begin
      b = (i == 0) ? 8'h07 : 8'($urandom);
      write_byte(b);
      device_frame(11, 1, smp, low, inh);
      checks++;
      if (smp !== frame_of(b)) begin errors++; $display("FAIL rand_frame %02h: got %b want %b", b, smp, frame_of(b)); end
      checks++;
      if (!inh) begin errors++; $display("FAIL rand_inhibit %02h: got rx_inhibit low during frame want high", b); end
      repeat (10) @(negedge clk);
      checks++;
      if (data_out !== 3'b010 || rx_inhibit !== 1'b0) begin errors++; $display("FAIL rand_status %02h: got %b inhibit=%b want 010 0", b, data_out, rx_inhibit); end
    end
  endtask

  task automatic test_noack;
    logic [10:0] smp;
    int low;
    bit inh;
    write_byte(8'($urandom));
    device_frame(11, 0, smp, low, inh);
    repeat (10) @(negedge clk);
    checks++;
    if (data_out !== 3'b100) begin errors++; $display("FAIL noack_status: got %b want 100", data_out); end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL noack_oe: got %b %b want 0 0", ps2_clk_oe, ps2_data_oe); end
  endtask

  task automatic test_busy_write;
    logic [10:0] smp;
    int low;
    bit inh;
    write_byte(8'h3C);
    write_byte(8'hFF);
    device_frame(11, 1, smp, low, inh);
    checks++;
    if (smp !== frame_of(8'h3C)) begin errors++; $display("FAIL busy_write_frame: got %b want %b", smp, frame_of(8'h3C)); end
    repeat (10) @(negedge clk);
    checks++;
    if (data_out !== 3'b010) begin errors++; $display("FAIL busy_write_status: got %b want 010", data_out); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] smp;
    int low;
    bit inh;
    write_byte(8'hA5);
    device_frame(5, 1, smp, low, inh);
    checks++;
    if (ps2_data_oe !== 1'b1 || data_out !== 3'b001) begin errors++; $display("FAIL mid_before_rst: got data_oe=%b status=%b want 1 001", ps2_data_oe, data_out); end
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL mid_async_oe: got %b %b want 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++;
    if (data_out !== 3'b000) begin errors++; $display("FAIL mid_status: got %b want 000", data_out); end
    @(negedge clk);
    rst = 0;
    write_byte(8'hF4);
    device_frame(11, 1, smp, low, inh);
    checks++;
    if (smp !== frame_of(8'hF4)) begin errors++; $display("FAIL mid_f4_frame: got %b want %b", smp, frame_of(8'hF4)); end
    repeat (10) @(negedge clk);
    checks++;
    if (data_out !== 3'b010) begin errors++; $display("FAIL mid_f4_status: got %b want 010", data_out); end
  endtask

  task automatic test_stall;
    logic [10:0] smp;
    int low;
    bit inh;
    write_byte(8'($urandom));
    device_frame(5, 1, smp, low, inh);
    repeat (TMO + 100) @(negedge clk);
`ifdef XPS2_TX_WDOG_EN
    checks++;
    if (data_out !== 3'b100) begin errors++; $display("FAIL stall_status: got %b want 100", data_out); end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL stall_oe: got %b %b want 0 0", ps2_clk_oe, ps2_data_oe); end
`else
    checks++;
    if (data_out !== 3'b001 || rx_inhibit !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b inhibit=%b want 001 1", data_out, rx_inhibit); end
    checks++;
    if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL stall_clk_oe: got %b want 0", ps2_clk_oe); end
`endif
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ed();
    test_random();
    test_noack();
    test_busy_write();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
